// File: rtl/matmul_tile_ctrl.sv
// Control path for the MAC array: per output tile it clears the accumulators, runs a
// handshaked K reduction, flushes the MAC pipeline and hands the tile result downstream.
//
// state | meaning
// IDLE  | waiting for start; config is checked here
// CLEAR | one-cycle accumulator clear for the current tile
// RUN   | consuming operands, one accumulate per in_valid
// FLUSH | draining PIPE_LAT cycles of MAC pipeline
// EMIT  | presenting the tile result until out_ready
// DONE  | one-cycle completion pulse
module matmul_tile_ctrl #(
  parameter int MAX_K     = 16,
  parameter int MAX_TILES = 8,
  parameter int PIPE_LAT  = 2,
  localparam int KW = $clog2(MAX_K + 1),
  localparam int TW = $clog2(MAX_TILES + 1),
  localparam int FW = $clog2(PIPE_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] cfg_k,
  input  logic [TW-1:0] cfg_tiles,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          en,
  output logic          clear,
  output logic [KW-1:0] k,
  output logic [TW-1:0] tile,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  // A zero-latency build still needs a one-bit counter to keep widths legal.
  localparam int FW_C = (FW < 1) ? 1 : FW;
  localparam logic [FW_C-1:0] FLUSH_LAST = FW_C'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [TW-1:0]   tile_q, tile_d;
  logic [FW_C-1:0] flush_q, flush_d;
  logic [KW-1:0]   cfg_k_q, cfg_k_d;
  logic [TW-1:0]   cfg_tiles_q, cfg_tiles_d;
  logic            cfg_err_q, cfg_err_d;
  logic            cfg_ok;

  assign cfg_ok = (cfg_k != '0) && (cfg_k <= KW'(MAX_K)) &&
                  (cfg_tiles != '0) && (cfg_tiles <= TW'(MAX_TILES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      tile_q      <= '0;
      flush_q     <= '0;
      cfg_k_q     <= '0;
      cfg_tiles_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      tile_q      <= tile_d;
      flush_q     <= flush_d;
      cfg_k_q     <= cfg_k_d;
      cfg_tiles_q <= cfg_tiles_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    tile_d      = tile_q;
    flush_d     = flush_q;
    cfg_k_d     = cfg_k_q;
    cfg_tiles_d = cfg_tiles_q;
    cfg_err_d   = cfg_err_q;

    case (state_q)
      S_IDLE: begin
        // abort in IDLE swallows a same-cycle start, including its config check
        if (start && !abort) begin
          if (cfg_ok) begin
            cfg_k_d     = cfg_k;
            cfg_tiles_d = cfg_tiles;
            cfg_err_d   = 1'b0;
            tile_d      = '0;
            k_d         = '0;
            state_d     = S_CLEAR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        k_d     = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (in_valid) begin
          if (k_q == cfg_k_q - 1'b1) begin
            k_d     = '0;
            flush_d = '0;
            state_d = (PIPE_LAT == 0) ? S_EMIT : S_FLUSH;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          flush_d = '0;
          state_d = S_EMIT;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (tile_q == cfg_tiles_q - 1'b1) begin
            state_d = S_DONE;
          end else begin
            tile_d  = tile_q + 1'b1;
            state_d = S_CLEAR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // abort overrides every transition above, including the EMIT handshake
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      k_d     = '0;
      tile_d  = '0;
      flush_d = '0;
    end
  end

  assign in_ready  = (state_q == S_RUN);
  assign en        = (state_q == S_RUN) && in_valid;
  assign clear     = (state_q == S_CLEAR);
  assign k         = k_q;
  assign tile      = tile_q;
  assign out_valid = (state_q == S_EMIT);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_matmul_tile_ctrl.sv
// Bench for matmul_tile_ctrl: config table, timeline-model jobs (PIPE_LAT=2 and 0 builds
// side by side) and hand sequences for abort and mid-job reset.
module tb_matmul_tile_ctrl;
  localparam int MAX_K = 16;
  localparam int MAX_TILES = 8;
  localparam int KW = $clog2(MAX_K + 1);
  localparam int TW = $clog2(MAX_TILES + 1);
  localparam int OW = 7 + KW + TW;
  localparam int N = 1024;

  logic clk = 1'b0;
  logic rst_n, start, abort, in_valid, out_ready;
  logic [KW-1:0] cfg_k;
  logic [TW-1:0] cfg_tiles;

  logic in_ready_a, en_a, clear_a, out_valid_a, busy_a, done_a, cfg_err_a;
  logic [KW-1:0] k_a;
  logic [TW-1:0] tile_a;
  logic in_ready_b, en_b, clear_b, out_valid_b, busy_b, done_b, cfg_err_b;
  logic [KW-1:0] k_b;
  logic [TW-1:0] tile_b;
  logic [OW-1:0] obs_a, obs_b;

  assign obs_a = {in_ready_a, en_a, clear_a, k_a, tile_a, out_valid_a, busy_a, done_a, cfg_err_a};
  assign obs_b = {in_ready_b, en_b, clear_b, k_b, tile_b, out_valid_b, busy_b, done_b, cfg_err_b};

  always #5 clk = ~clk;

  matmul_tile_ctrl #(.MAX_K(MAX_K), .MAX_TILES(MAX_TILES), .PIPE_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_tiles(cfg_tiles),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready_a), .en(en_a), .clear(clear_a),
    .k(k_a), .tile(tile_a), .out_valid(out_valid_a), .out_ready(out_ready), .busy(busy_a),
    .done(done_a), .cfg_err(cfg_err_a));

  matmul_tile_ctrl #(.MAX_K(MAX_K), .MAX_TILES(MAX_TILES), .PIPE_LAT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_tiles(cfg_tiles),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready_b), .en(en_b), .clear(clear_b),
    .k(k_b), .tile(tile_b), .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b),
    .done(done_b), .cfg_err(cfg_err_b));

  int checks = 0;
  int failures = 0;
  int n_clear, n_en, n_hs, n_done, done_cyc_a, done_cyc_b;

  bit iv [N];
  bit ordy [N];
  logic [OW-1:0] expv [2][N];
  int endc [2];

  typedef struct {
    logic          st;
    logic [KW-1:0] ck;
    logic [TW-1:0] ct;
    logic          ab;
    logic          exp_busy;
    logic          exp_err;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [OW-1:0] pk(int ir, int e, int cl, int kv, int tv, int ov, int bz,
                                       int dn, int er);
    return {ir[0], e[0], cl[0], kv[KW-1:0], tv[TW-1:0], ov[0], bz[0], dn[0], er[0]};
  endfunction

  task automatic put(input int d, input int p, input logic [OW-1:0] v);
    if (p >= 0 && p < N) expv[d][p] = v;
  endtask

  // Expected output timeline of one job, walked tile by tile over the planned
  // in_valid/out_ready streams; cycle 0 is the start cycle.
  task automatic build(input int d, input int pl, input int kk, input int tt);
    int p;
    p = 1;
    for (int c = 0; c < N; c++) expv[d][c] = '0;
    for (int t = 0; t < tt; t++) begin
      put(d, p, pk(0, 0, 1, 0, t, 0, 1, 0, 0)); p++;
      for (int j = 0; j < kk; j++) begin
        while (p < N && !iv[p]) begin put(d, p, pk(1, 0, 0, j, t, 0, 1, 0, 0)); p++; end
        put(d, p, pk(1, 1, 0, j, t, 0, 1, 0, 0)); p++;
      end
      for (int f = 0; f < pl; f++) begin put(d, p, pk(0, 0, 0, 0, t, 0, 1, 0, 0)); p++; end
      while (p < N && !ordy[p]) begin put(d, p, pk(0, 0, 0, 0, t, 1, 1, 0, 0)); p++; end
      put(d, p, pk(0, 0, 0, 0, t, 1, 1, 0, 0)); p++;
    end
    put(d, p, pk(0, 0, 0, 0, tt - 1, 0, 1, 1, 0)); p++;
    endc[d] = p;
    for (int c = p; c < N; c++) expv[d][c] = pk(0, 0, 0, 0, tt - 1, 0, 0, 0, 0);
  endtask

  task automatic run_job(input int kk, input int tt);
    int last;
    do_reset();
    build(0, 2, kk, tt);
    build(1, 0, kk, tt);
    last = ((endc[0] > endc[1]) ? endc[0] : endc[1]) + 2;
    if (last > N) last = N;
    n_clear = 0; n_en = 0; n_hs = 0; n_done = 0; done_cyc_a = -1; done_cyc_b = -1;
    cfg_k = KW'(kk);
    cfg_tiles = TW'(tt);
    for (int c = 0; c < last; c++) begin
      start = (c == 0);
      in_valid = iv[c];
      out_ready = ordy[c];
      #1;
      chk($sformatf("cyc_a k%0d t%0d c%0d", kk, tt, c), 32'(obs_a), 32'(expv[0][c]));
      chk($sformatf("cyc_b k%0d t%0d c%0d", kk, tt, c), 32'(obs_b), 32'(expv[1][c]));
      if (clear_a) n_clear++;
      if (en_a) n_en++;
      if (out_valid_a && out_ready) n_hs++;
      if (done_a) begin
        n_done++;
        if (done_cyc_a < 0) done_cyc_a = c;
      end
      if (done_b && done_cyc_b < 0) done_cyc_b = c;
      tick();
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic fill_ones();
    for (int c = 0; c < N; c++) begin iv[c] = 1'b1; ordy[c] = 1'b1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int kk, tt;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_k = '0; cfg_tiles = '0;

    //            st    ck  ct  ab    busy  err
    tbl[0]  = '{1'b0,  4,  1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1,  0,  1, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 17,  1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1,  4,  1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1,  1,  0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1,  1,  9, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0,  4,  4, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 16,  8, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1,  2,  2, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1,  0,  1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1,  0,  3, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1,  1,  1, 1'b0, 1'b1, 1'b0};

    do_reset();
    chk("reset_a", 32'(obs_a), 32'd0);
    chk("reset_b", 32'(obs_b), 32'd0);

    for (int i = 0; i < 12; i++) begin
      cfg_k = tbl[i].ck; cfg_tiles = tbl[i].ct; start = tbl[i].st; abort = tbl[i].ab;
      tick();
      start = 1'b0; abort = 1'b0;
      #1;
      chk($sformatf("cfg_busy %0d", i), 32'(busy_a), 32'(tbl[i].exp_busy));
      chk($sformatf("cfg_err %0d", i), 32'(cfg_err_a), 32'(tbl[i].exp_err));
      if (busy_a) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
    end

    fill_ones();
    run_job(4, 1);
    chk("basic_done_cyc", done_cyc_a, 9);
    chk("basic_done_cyc_pl0", done_cyc_b, 7);
    chk("basic_en_count", n_en, 4);
    chk("basic_clear_count", n_clear, 1);

    fill_ones();
    iv[3] = 1'b0; iv[4] = 1'b0;
    run_job(3, 1);
    chk("stall_en_count", n_en, 3);
    chk("stall_done_cyc", done_cyc_a, 10);

    fill_ones();
    ordy[12] = 1'b0; ordy[13] = 1'b0; ordy[14] = 1'b0;
    run_job(2, 3);
    chk("bp_clear_count", n_clear, 3);
    chk("bp_en_count", n_en, 6);
    chk("bp_hs_count", n_hs, 3);
    chk("bp_done_count", n_done, 1);

    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < N; c++) begin
        iv[c] = ($urandom_range(3, 0) != 0);
        ordy[c] = $urandom_range(1, 0) != 0;
      end
      kk = (r == 0) ? MAX_K : int'($urandom_range(MAX_K, 1));
      tt = (r == 0) ? MAX_TILES : int'($urandom_range(MAX_TILES, 1));
      run_job(kk, tt);
      chk($sformatf("rand_en_count %0d", r), n_en, kk * tt);
      chk($sformatf("rand_done_count %0d", r), n_done, 1);
    end

    // abort in RUN at k=2
    do_reset();
    cfg_k = 8; cfg_tiles = 1; in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int b = 0; b < 40; b++) begin
      if (en_a && k_a == 2) begin found = 1; break; end
      tick();
    end
    chk("abort_run_reach", found, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_run_idle", 32'({busy_a, k_a, tile_a, done_a}), 32'd0);
    n_done = 0;
    for (int b = 0; b < 12; b++) begin
      if (done_a || busy_a) n_done++;
      tick();
    end
    chk("abort_run_quiet", n_done, 0);

    // abort in EMIT together with the handshake
    cfg_k = 1; cfg_tiles = 2; in_valid = 1'b1; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int b = 0; b < 40; b++) begin
      if (out_valid_a) begin found = 1; break; end
      tick();
    end
    chk("abort_emit_reach", found, 1);
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0; out_ready = 1'b0;
    chk("abort_emit_idle", 32'({busy_a, k_a, tile_a, out_valid_a, done_a}), 32'd0);
    n_done = 0;
    for (int b = 0; b < 12; b++) begin
      if (done_a || busy_a) n_done++;
      tick();
    end
    chk("abort_emit_quiet", n_done, 0);

    // reset clears a sticky error, and a reset in FLUSH drops everything
    do_reset();
    cfg_k = 0; cfg_tiles = 1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_set", 32'(cfg_err_a), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("reset_clears_err", 32'(cfg_err_a), 32'd0);

    cfg_k = 4; cfg_tiles = 2; in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int b = 0; b < 40; b++) begin
      if (en_a && k_a == 3) begin found = 1; break; end
      tick();
    end
    chk("rst_mid_reach", found, 1);
    tick();
    chk("rst_mid_flush", 32'({busy_a, in_ready_a, en_a, out_valid_a, clear_a}), 32'b10000);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_a", 32'(obs_a), 32'd0);
    chk("rst_mid_b", 32'(obs_b), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/matmul_tile_ctrl.md
Name: matmul_tile_ctrl

Overview:
- Second-generation control path for the MAC array.
- Sequences a multi-tile matrix multiply: per output tile it clears the accumulators, runs a runtime-programmable K reduction gated by an operand-valid handshake, flushes the MAC pipeline, then presents the tile result with a valid/ready handshake.
- Sits between the AXI-side operand/result buffers and the MAC datapath.
- Adds runtime K, tile looping, stalls, abort and config-error reporting.

Parameters:
- MAX_K, 16: largest supported reduction length (cfg_k upper bound).
- MAX_TILES, 8: largest supported tile count per job.
- PIPE_LAT, 2: MAC pipeline depth; FLUSH cycles after the last accumulate (0 allowed).
- Derived: KW = $clog2(MAX_K+1), TW = $clog2(MAX_TILES+1), FW = $clog2(PIPE_LAT+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  job request; sampled only in IDLE
- cfg_k  in  KW  reduction length, 1..MAX_K; latched on accepted start
- cfg_tiles  in  TW  tile count, 1..MAX_TILES; latched on accepted start
- abort  in  1  cancels the job from any non-IDLE state
- in_valid  in  1  operand pair for current k available
- in_ready  out  1  controller consuming operands (high in RUN)
- en  out  1  MAC accumulate enable
- clear  out  1  accumulator clear
- k  out  KW  current reduction index
- tile  out  TW  current tile index
- out_valid  out  1  tile result valid
- out_ready  in  1  result consumer ready
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at job completion
- cfg_err  out  1  sticky config error; cleared by the next accepted start

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; k=0, tile=0, flush count=0, latched cfg=0, cfg_err=0. All outputs 0.
- States: IDLE, CLEAR, RUN, FLUSH, EMIT, DONE.
- IDLE:
  - start=1 with valid cfg (1<=cfg_k<=MAX_K, 1<=cfg_tiles<=MAX_TILES): latch cfg, cfg_err<=0, tile<=0, go to CLEAR.
  - start=1 with invalid cfg: cfg_err<=1, stay IDLE.
- CLEAR: clear=1 for exactly one cycle; k<=0; go to RUN.
- RUN:
  - in_ready=1; en = in_valid (combinational); k increments only when en=1.
  - In_valid low stalls: k holds, en=0, no timeout.
  - en=1 with k==cfg_k-1: k<=0; go to FLUSH, or to EMIT if PIPE_LAT=0.
- FLUSH: exactly PIPE_LAT cycles, then EMIT; en=0, in_ready=0.
- EMIT:
  - out_valid=1, held until out_ready=1; out_valid stays stable while out_ready=0.
  - On the handshake: if tile==cfg_tiles-1, go to DONE; else tile<=tile+1 and go to CLEAR.
- DONE: done=1 for one cycle; then IDLE. start is not sampled in DONE; back-to-back jobs need start in IDLE.
- Outputs: all except en are decoded from registered state (Moore). en = (state==RUN) & in_valid.
- Invariants:
  - en implies k<cfg_k.
  - clear and en are never high together.
  - out_valid only in EMIT.
  - Exactly cfg_k en pulses between consecutive clear pulses.
- abort:
  - In any non-IDLE state: next state IDLE; k, tile and flush count cleared; no done pulse. abort takes priority over every other transition, including the EMIT handshake in the same cycle.
  - In IDLE, abort is ignored and takes priority over start; a start in the same cycle is dropped.
- start while busy: ignored; latched cfg is unchanged mid-job.
- Reset mid-operation: same as power-on reset; cfg_err is also cleared.
- Width/wrap: k and tile never wrap. cfg_k=MAX_K runs k 0..MAX_K-1 with no overflow because k is KW bits wide.

Test Plan:
- Basic, cfg_k=4, cfg_tiles=1, PIPE_LAT=2, in_valid=1, out_ready=1 -> clear one cycle, then en for 4 cycles with k=0,1,2,3, 2 FLUSH cycles, out_valid one cycle, done one cycle 9 cycles after the start cycle.
- Stall: cfg_k=3, in_valid low for 2 cycles after k=1 -> k holds 1, en=0 during the stall, still exactly 3 en pulses, FLUSH entered only after the k=2 accumulate.
- Multi-tile with backpressure: cfg_k=2, cfg_tiles=3, out_ready low for 3 cycles in tile 1 -> out_valid held, tile stays 1; 3 clear pulses, 6 en pulses, 3 handshakes, one done, tile sequence 0,1,2.
- Config error: cfg_k=0 then cfg_k=MAX_K+1 -> cfg_err=1, busy stays 0. A following valid start clears cfg_err and the job completes.
- Abort: assert abort in RUN at k=2 (cfg_k=8), then again in EMIT together with out_ready=1 -> both cases reach IDLE next cycle, k=0, tile=0, no done, no handshake counted.
- Reset mid-job and PIPE_LAT=0 build: rst_n low in FLUSH -> all outputs 0 next cycle. With PIPE_LAT=0: RUN goes directly to EMIT after the last en.
